// File: rtl/bcd_to_bin_if.sv
// Request/result bundle for the 3-digit BCD to binary converter.
// The master drives the request; the slave returns result and status.
interface bcd_to_bin_if;
    logic        synch;
    logic [3:0]  dec_in1;
    logic [3:0]  dec_in2;
    logic [3:0]  dec_in3;
    logic [11:0] bin_out;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output synch, dec_in1, dec_in2, dec_in3,
        input  bin_out, busy, done, err
    );

    modport slave (
        input  synch, dec_in1, dec_in2, dec_in3,
        output bin_out, busy, done, err
    );
endinterface

// File: rtl/bcd_to_bin.sv
// Sequential 3-digit BCD to binary converter using reverse double-dabble.
// It performs 12 shifts with an add-minus-3 correction between them.
module bcd_to_bin (
    input  logic         clk,
    input  logic         rst,
    bcd_to_bin_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_ADJUST,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [11:0] r_bcd;
    logic [11:0] r_bin;
    logic [3:0]  r_cnt;
    logic [11:0] r_bin_out;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    logic        w_invalid;
    logic [11:0] w_bcd_adj;

    function automatic logic [3:0] adj_nibble(input logic [3:0] n);
        return (n >= 4'd8) ? (n - 4'd3) : n;
    endfunction

    assign w_invalid = (bus.dec_in1 > 4'd9) || (bus.dec_in2 > 4'd9) || (bus.dec_in3 > 4'd9);

    // Every nibble is corrected from the pre-cycle register value, never from a partial update.
    assign w_bcd_adj = {adj_nibble(r_bcd[11:8]), adj_nibble(r_bcd[7:4]), adj_nibble(r_bcd[3:0])};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_bcd     <= '0;
            r_bin     <= '0;
            r_cnt     <= '0;
            r_bin_out <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.synch) begin
                        if (w_invalid) begin
                            r_err  <= 1'b1;
                            r_done <= 1'b1;
                        end else begin
                            r_bcd   <= {bus.dec_in1, bus.dec_in2, bus.dec_in3};
                            r_bin   <= '0;
                            r_cnt   <= '0;
                            r_err   <= 1'b0;
                            r_busy  <= 1'b1;
                            r_state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    {r_bcd, r_bin} <= {1'b0, r_bcd, r_bin[11:1]};
                    r_cnt          <= r_cnt + 4'd1;
                    r_state        <= (r_cnt == 4'd11) ? S_DONE : S_ADJUST;
                end
                S_ADJUST: begin
                    r_bcd   <= w_bcd_adj;
                    r_state <= S_SHIFT;
                end
                S_DONE: begin
                    r_bin_out <= r_bin;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.bin_out = r_bin_out;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.err     = r_err;
endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: directed scenarios plus randomized
// requests compared against a decimal-arithmetic reference model.
module tb_bcd_to_bin;
    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   exp_last;

    bcd_to_bin_if bus_if ();

    bcd_to_bin dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain decimal weighting of the three digits.
    function automatic int model_value(input int d1, input int d2, input int d3);
        return d1 * 100 + d2 * 10 + d3;
    endfunction

    // Advance one active edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_digits(input int d1, input int d2, input int d3);
        bus_if.dec_in1 = 4'(d1);
        bus_if.dec_in2 = 4'(d2);
        bus_if.dec_in3 = 4'(d3);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_if.synch = 1'b0;
        set_digits(0, 0, 0);
        tick();
        tick();
        checks++;
        if (bus_if.bin_out !== 12'd0 || bus_if.busy !== 1'b0 || bus_if.done !== 1'b0 || bus_if.err !== 1'b0) begin
            errors++;
            $display("FAIL reset: bin_out=%0d busy=%b done=%b err=%b, required 0/0/0/0",
                     bus_if.bin_out, bus_if.busy, bus_if.done, bus_if.err);
        end
        rst = 1'b0;
        exp_last = 0;
    endtask

    task automatic test_max_value();
        set_digits(9, 9, 9);
        bus_if.synch = 1'b1;
        tick();
        bus_if.synch = 1'b0;
        checks++;
        if (bus_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL max_busy_accept: busy=%b required 1", bus_if.busy);
        end
        for (int e = 1; e <= 24; e++) begin
            tick();
            if (e < 24) begin
                checks++;
                if (bus_if.busy !== 1'b1 || bus_if.done !== 1'b0) begin
                    errors++;
                    $display("FAIL max_busy edge %0d: busy=%b done=%b required 1/0", e, bus_if.busy, bus_if.done);
                end
            end
        end
        exp_last = model_value(9, 9, 9);
        checks++;
        if (bus_if.done !== 1'b1 || bus_if.busy !== 1'b0 || bus_if.err !== 1'b0 ||
            bus_if.bin_out !== 12'(exp_last)) begin
            errors++;
            $display("FAIL max_done: done=%b busy=%b err=%b bin_out=%0d required 1/0/0/%0d",
                     bus_if.done, bus_if.busy, bus_if.err, bus_if.bin_out, exp_last);
        end
        tick();
        checks++;
        if (bus_if.done !== 1'b0) begin
            errors++;
            $display("FAIL max_done_width: done=%b required 0", bus_if.done);
        end
    endtask

    task automatic test_patterns();
        int d [3];
        int n;
        for (int k = 0; k < 22; k++) begin
            if (k == 0) begin
                d[0] = 1; d[1] = 9; d[2] = 0;
            end else if (k == 1) begin
                d[0] = 0; d[1] = 0; d[2] = 0;
            end else begin
                for (int j = 0; j < 3; j++) d[j] = int'($urandom_range(9));
            end
            set_digits(d[0], d[1], d[2]);
            bus_if.synch = 1'b1;
            tick();
            bus_if.synch = 1'b0;
            n = 0;
            do begin
                tick();
                n++;
            end while (bus_if.done !== 1'b1 && n < 40);
            exp_last = model_value(d[0], d[1], d[2]);
            checks++;
            if (n != 24 || bus_if.bin_out !== 12'(exp_last) || bus_if.err !== 1'b0) begin
                errors++;
                $display("FAIL pattern %0d%0d%0d: latency=%0d bin_out=%0d err=%b required 24/%0d/0",
                         d[0], d[1], d[2], n, bus_if.bin_out, bus_if.err, exp_last);
            end
            tick();
            checks++;
            if (bus_if.done !== 1'b0) begin
                errors++;
                $display("FAIL pattern_done_width %0d: done=%b required 0", k, bus_if.done);
            end
        end
    endtask

    task automatic test_invalid();
        int d [3];
        for (int k = 0; k < 6; k++) begin
            if (k == 0) begin
                d[0] = 0; d[1] = 10; d[2] = 5;
            end else begin
                for (int j = 0; j < 3; j++) d[j] = int'($urandom_range(15));
                d[$urandom_range(2)] = int'($urandom_range(15, 10));
            end
            set_digits(d[0], d[1], d[2]);
            bus_if.synch = 1'b1;
            tick();
            bus_if.synch = 1'b0;
            checks++;
            if (bus_if.err !== 1'b1 || bus_if.done !== 1'b1 || bus_if.busy !== 1'b0 ||
                bus_if.bin_out !== 12'(exp_last)) begin
                errors++;
                $display("FAIL invalid %0d,%0d,%0d: err=%b done=%b busy=%b bin_out=%0d required 1/1/0/%0d",
                         d[0], d[1], d[2], bus_if.err, bus_if.done, bus_if.busy, bus_if.bin_out, exp_last);
            end
            tick();
            checks++;
            if (bus_if.done !== 1'b0 || bus_if.err !== 1'b1 || bus_if.busy !== 1'b0) begin
                errors++;
                $display("FAIL invalid_hold: done=%b err=%b busy=%b required 0/1/0",
                         bus_if.done, bus_if.err, bus_if.busy);
            end
        end
    endtask

    task automatic test_digit_change();
        int dones;
        int first_done;
        set_digits(4, 5, 6);
        bus_if.synch = 1'b1;
        tick();
        bus_if.synch = 1'b0;
        dones = 0;
        first_done = -1;
        for (int e = 1; e <= 30; e++) begin
            tick();
            if (bus_if.done === 1'b1) begin
                dones++;
                if (first_done < 0) first_done = e;
                exp_last = model_value(4, 5, 6);
                checks++;
                if (bus_if.bin_out !== 12'(exp_last)) begin
                    errors++;
                    $display("FAIL change_value: bin_out=%0d required %0d", bus_if.bin_out, exp_last);
                end
            end
            if (e == 10) begin
                set_digits(7, 8, 9);
                bus_if.synch = 1'b1;
            end else begin
                bus_if.synch = 1'b0;
            end
        end
        checks++;
        if (dones != 1 || first_done != 24) begin
            errors++;
            $display("FAIL change_done: count=%0d edge=%0d required 1/24", dones, first_done);
        end
    endtask

    task automatic test_reset_abort();
        int n;
        set_digits(9, 9, 9);
        bus_if.synch = 1'b1;
        tick();
        bus_if.synch = 1'b0;
        for (int e = 1; e <= 11; e++) tick();
        rst = 1'b1;
        tick();
        exp_last = 0;
        checks++;
        if (bus_if.bin_out !== 12'd0 || bus_if.busy !== 1'b0 || bus_if.done !== 1'b0 || bus_if.err !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: bin_out=%0d busy=%b done=%b err=%b required 0/0/0/0",
                     bus_if.bin_out, bus_if.busy, bus_if.done, bus_if.err);
        end
        rst = 1'b0;
        set_digits(0, 4, 2);
        bus_if.synch = 1'b1;
        tick();
        bus_if.synch = 1'b0;
        checks++;
        if (bus_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_accept: busy=%b required 1", bus_if.busy);
        end
        n = 0;
        do begin
            tick();
            n++;
        end while (bus_if.done !== 1'b1 && n < 40);
        exp_last = model_value(0, 4, 2);
        checks++;
        if (n != 24 || bus_if.bin_out !== 12'(exp_last)) begin
            errors++;
            $display("FAIL abort_new: latency=%0d bin_out=%0d required 24/%0d", n, bus_if.bin_out, exp_last);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int want_gap;
        set_digits(0, 0, 0);
        bus_if.synch = 1'b1;
        tick();
        for (int v = 0; v < 1000; v++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (bus_if.done !== 1'b1 && n < 40);
            want_gap = (v == 0) ? 24 : 25;
            checks++;
            if (n != want_gap || bus_if.bin_out !== 12'(v)) begin
                errors++;
                $display("FAIL sweep %0d: gap=%0d bin_out=%0d required %0d/%0d", v, n, bus_if.bin_out, want_gap, v);
            end
            if (n >= 40) break;
            if (v < 999) set_digits((v + 1) / 100, ((v + 1) / 10) % 10, (v + 1) % 10);
            else bus_if.synch = 1'b0;
        end
        bus_if.synch = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_max_value();
        test_patterns();
        test_invalid();
        test_digit_change();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bcd_to_bin.md
BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 SHALL use one clock, posedge-triggered; reset is synchronous and active-high.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 synch  input  1  start request, sampled only in IDLE.
REQ-005 dec_in1  input  4  hundreds BCD digit.
REQ-006 dec_in2  input  4  tens BCD digit.
REQ-007 dec_in3  input  4  ones BCD digit.
REQ-008 bin_out  output  12  unsigned binary result, registered, range 0..999.
REQ-009 busy  output  1  high while a conversion is in progress.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 err  output  1  invalid-digit flag for the last request.

Function
REQ-012 SHALL implement a four-state FSM: IDLE, SHIFT, ADJUST, DONE.
REQ-013 SHALL hold a 12-bit BCD work register bcd, a 12-bit binary work register bin and a 4-bit iteration counter cnt.
REQ-014 IDLE, synch=1, all digits <=9: load bcd={dec_in1,dec_in2,dec_in3}, bin=0, cnt=0, err<=0, busy<=1, go to SHIFT.
REQ-015 IDLE, synch=1, any digit >9: err<=1 and done<=1 on the next edge; bin_out unchanged; busy stays 0; state stays IDLE.
REQ-016 SHIFT: shift {bcd,bin} right by one as a 24-bit value, with 0 entering bcd[11]; cnt<=cnt+1; go to DONE if cnt==11, else go to ADJUST.
REQ-017 ADJUST: subtract 3 from each bcd nibble independently when that nibble is >=8, then go to SHIFT.
REQ-018 ADJUST: each nibble SHALL be tested against the value it held before this cycle, never against a partially updated register.
REQ-019 DONE: bin_out<=bin, done<=1 for exactly one cycle, busy<=0, go to IDLE.
REQ-020 Latency: exactly 12 SHIFT cycles and 11 ADJUST cycles per conversion.
REQ-021 Valid requests: done and the new bin_out appear after the 24th edge following the edge that sampled synch.
REQ-022 Invalid requests (REQ-015): done and err appear after the 1st edge following the edge that sampled synch.
REQ-023 synch while busy=1 SHALL be ignored; it neither restarts nor queues a conversion.
REQ-024 synch held high SHALL start a new conversion on the first IDLE cycle after DONE.
REQ-025 Digit inputs SHALL be sampled only on the accepting edge; later changes SHALL not affect the running result.
REQ-026 bin_out SHALL hold its last value until the next DONE; err SHALL hold until the next accepted synch.
REQ-027 done SHALL be 0 in every cycle other than those defined in REQ-015 and REQ-019.
REQ-028 Arithmetic SHALL be unsigned modulo 16 per nibble; with valid inputs no nibble underflows.

Reset
REQ-029 rst=1 SHALL force state=IDLE, bin_out=0, busy=0, done=0, err=0, bcd=0, bin=0, cnt=0 on the next edge.
REQ-030 rst SHALL take priority over synch and over every FSM state.
REQ-031 rst asserted mid-conversion SHALL abort it; no done pulse for the aborted request.
REQ-032 After rst deasserts, the block SHALL accept synch on the first following edge.

Verification
REQ-033 digits 9,9,9 with synch pulse -> done after edge 24, bin_out=0x3E7, err=0, busy high for edges 1..23.
REQ-034 digits 1,9,0 -> bin_out=0x0BE; then digits 0,0,0 -> bin_out=0x000, done pulse of width 1 each time.
REQ-035 digits 0,0xA,5 -> err=1 and done after edge 1, busy=0, bin_out keeps its previous value.
REQ-036 start 4,5,6; pulse synch and change digits to 7,8,9 at edge 10 -> single done at edge 24, bin_out=0x1C8.
REQ-037 start 9,9,9; assert rst at edge 12 -> all outputs 0, no done; new request 0,4,2 -> bin_out=0x02A.
REQ-038 exhaustive sweep 000..999 back-to-back with synch held high -> every result equals the decimal value, gap between done pulses is 25 cycles.
